regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the CPU core, with a dedicated HI/LO pair and a per-register busy scoreboard. It serves the decode stage: NR combinational read ports with same-cycle write bypass, and two write ports (WB main, WB secondary/late). The scoreboard tracks registers with an in-flight producer so decode can raise a stall. Reset is asynchronous and clears all architectural state.

Parameters:
DW, 32, data width of GPRs and HI/LO
AW, 5, register address width; depth = 2**AW
NR, 2, number of read ports (1..4)
ZERO_R0, 1, 1 = register 0 reads 0 and ignores writes
BYPASS, 1, 1 = a read of an address written this cycle returns the write data

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
raddr  in  NR*AW  read addresses; port i = raddr[i*AW +: AW]
rdata  out  NR*DW  read data; port i = rdata[i*DW +: DW]
rbusy  out  NR  scoreboard busy bit of each read address
we0  in  1  write port 0 enable
waddr0  in  AW  write port 0 address
wdata0  in  DW  write port 0 data
we1  in  1  write port 1 enable (higher priority)
waddr1  in  AW  write port 1 address
wdata1  in  DW  write port 1 data
hi_we  in  1  HI write enable
hi_wdata  in  DW  HI write data
lo_we  in  1  LO write enable
lo_wdata  in  DW  LO write data
hi_rdata  out  DW  HI read value
lo_rdata  out  DW  LO read value
sb_set  in  1  mark sb_addr busy (issue of a producer)
sb_addr  in  AW  scoreboard set address
sb_flush  in  1  clear all busy bits (pipeline flush)

Behaviour:
- Reset (rst_n low, async): all GPRs, HI and LO <= 0; all busy bits <= 0. rdata/hi_rdata/lo_rdata therefore read 0, rbusy = 0. Writes during reset are ignored; first write takes effect on the first rising edge after rst_n deasserts.
- Writes: at posedge, if weK, reg[waddrK] <= wdataK. If we0 and we1 target the same address, port 1's data is stored. With ZERO_R0=1, writes to address 0 are dropped on both ports.
- HI/LO: independent of GPR writes (a GPR write never blocks an HI/LO write, and vice versa). hi_we/lo_we update HI/LO at posedge; both may update in the same cycle.
- Reads: combinational, zero latency. Priority per port: ZERO_R0 and raddr==0 -> 0; else BYPASS and we1 and waddr1==raddr -> wdata1; else BYPASS and we0 and waddr0==raddr -> wdata0; else stored value. A bypass never applies to address 0 when ZERO_R0=1.
- hi_rdata = (BYPASS and hi_we) ? hi_wdata : HI; lo_rdata likewise.
- With BYPASS=0, reads return the pre-edge stored value; the new value is visible the next cycle.
- Scoreboard: one busy bit per register.
  - Posedge clear: a write on either port to address A clears busy[A].
  - Posedge set: sb_set sets busy[sb_addr].
  - Set and clear of the same address in the same cycle: set wins (newer producer).
  - sb_flush clears all bits and overrides sb_set in the same cycle.
  - busy[0] is held at 0 when ZERO_R0=1.
  - rbusy[i] = busy[raddr_i] & ~(same-cycle write to raddr_i, when BYPASS=1), so a bypassed read is not reported busy.
- No X-propagation from uninitialised storage: every entry is reset.

Test Plan:
- Reset/zero: assert rst_n=0 mid-run after writing r5=0x1234 -> r5 reads 0 immediately (async), HI=LO=0, rbusy=0; write r0=0xFFFF_FFFF -> r0 reads 0.
- Write/read and bypass: we0, r3=0xDEAD_BEEF with raddr0=3 in the same cycle -> rdata0=0xDEADBEEF combinationally; next cycle with we0=0 -> still 0xDEADBEEF. With BYPASS=0 -> old value in the write cycle, new value the next.
- Dual-write collision: we0 r7=0x1, we1 r7=0x2 -> bypass read shows 0x2 and stored value is 0x2; different addresses r8=0xA, r9=0xB -> both stored.
- HI/LO: hi_we=1 with 0x55, lo_we=1 with 0xAA, plus we0 r4=0x77 in the same cycle -> all three stored; hi_rdata=0x55 during the write cycle.
- Scoreboard: sb_set r10 -> rbusy for raddr=10 is 1 the next cycle; we1 r10 with sb_set r10 in the same cycle -> stays busy; then a write only -> cleared; sb_flush with sb_set r11 -> no bit set.
- NR=4 build: four ports reading r1..r4 after distinct writes -> each returns its own data; port 2 bypasses a we1 hit independently.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port general-purpose register file for the decode stage.
// It has NR combinational read ports with optional same-cycle write bypass
// and two write ports, where port 1 wins a same-address collision.
// It also holds a HI/LO pair and a per-register busy scoreboard.
// All state is cleared by an asynchronous active-low reset.
module regfile_mp #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NR      = 2,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rbusy,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  logic [DW-1:0]    wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  logic [DW-1:0]    wdata1,
    input  logic             hi_we,
    input  logic [DW-1:0]    hi_wdata,
    input  logic             lo_we,
    input  logic [DW-1:0]    lo_wdata,
    output logic [DW-1:0]    hi_rdata,
    output logic [DW-1:0]    lo_rdata,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    input  logic             sb_flush
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;
    logic [DW-1:0]    r_hi;
    logic [DW-1:0]    r_lo;
    logic             w_wr0_ok;
    logic             w_wr1_ok;

    // A write to r0 is dropped when r0 is hard-wired to zero.
    assign w_wr0_ok = we0 && !(ZERO_R0 && (waddr0 == '0));
    assign w_wr1_ok = we1 && !(ZERO_R0 && (waddr1 == '0));

    // GPR storage: port 1 data wins when both ports hit the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr1_ok && (waddr1 == AW'(i))) begin
                    r_mem[i] <= wdata1;
                end else if (w_wr0_ok && (waddr0 == AW'(i))) begin
                    r_mem[i] <= wdata0;
                end
            end
        end
    end

    // HI/LO are separate from the GPR write ports and update independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (hi_we) r_hi <= hi_wdata;
            if (lo_we) r_lo <= lo_wdata;
        end
    end

    assign hi_rdata = (BYPASS && hi_we) ? hi_wdata : r_hi;
    assign lo_rdata = (BYPASS && lo_we) ? lo_wdata : r_lo;

    // Scoreboard next state. A writeback clears the bit first, so a new issue
    // to the same register in the same cycle stays busy. A flush overrides both.
    always_comb begin
        w_busy_next = r_busy;
        if (we0)      w_busy_next[waddr0] = 1'b0;
        if (we1)      w_busy_next[waddr1] = 1'b0;
        if (sb_set)   w_busy_next[sb_addr] = 1'b1;
        if (sb_flush) w_busy_next = '0;
        if (ZERO_R0)  w_busy_next[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Read ports. A read that is bypassed from a same-cycle write already
    // carries the producer's result, so it is not reported busy.
    genvar gi;
    generate
        for (gi = 0; gi < NR; gi++) begin : g_rd
            logic [AW-1:0] w_ra;
            logic          w_zero;
            logic          w_hit0;
            logic          w_hit1;

            assign w_ra   = raddr[gi*AW +: AW];
            assign w_zero = ZERO_R0 && (w_ra == '0);
            assign w_hit1 = BYPASS && we1 && (waddr1 == w_ra) && !w_zero;
            assign w_hit0 = BYPASS && we0 && (waddr0 == w_ra) && !w_zero;

            assign rdata[gi*DW +: DW] = w_zero ? '0 :
                                        w_hit1 ? wdata1 :
                                        w_hit0 ? wdata0 :
                                                 r_mem[w_ra];
            assign rbusy[gi] = r_busy[w_ra] & ~(w_hit0 | w_hit1);
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp. It runs two builds side by side from the same
// write, HI/LO and scoreboard inputs:
//   A: NR=4, ZERO_R0=1, BYPASS=1
//   B: NR=2, ZERO_R0=0, BYPASS=0
// Both builds are compared against an array-based reference model.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [19:0]  raddr_a;
    logic [127:0] rdata_a;
    logic [3:0]   rbusy_a;
    logic [9:0]   raddr_b;
    logic [63:0]  rdata_b;
    logic [1:0]   rbusy_b;
    logic         we0, we1, hi_we, lo_we, sb_set, sb_flush;
    logic [4:0]   waddr0, waddr1, sb_addr;
    logic [31:0]  wdata0, wdata1, hi_wdata, lo_wdata;
    logic [31:0]  hi_rdata_a, lo_rdata_a, hi_rdata_b, lo_rdata_b;

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = build A, index 1 = build B.
    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];
    logic [31:0] m_hi   [2];
    logic [31:0] m_lo   [2];

    always #5 clk = ~clk;

    regfile_mp #(.DW(32), .AW(5), .NR(4), .ZERO_R0(1'b1), .BYPASS(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .hi_we(hi_we), .hi_wdata(hi_wdata), .lo_we(lo_we), .lo_wdata(lo_wdata),
        .hi_rdata(hi_rdata_a), .lo_rdata(lo_rdata_a),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush));

    regfile_mp #(.DW(32), .AW(5), .NR(2), .ZERO_R0(1'b0), .BYPASS(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .hi_we(hi_we), .hi_wdata(hi_wdata), .lo_we(lo_we), .lo_wdata(lo_wdata),
        .hi_rdata(hi_rdata_b), .lo_rdata(lo_rdata_b),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush));

    function automatic bit cfg_zr(int k);
        return (k == 0);
    endfunction

    function automatic bit cfg_bp(int k);
        return (k == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[k][r]  = '0;
                m_busy[k][r] = 1'b0;
            end
            m_hi[k] = '0;
            m_lo[k] = '0;
        end
    endtask

    // Apply one clock edge of architectural effects to the model.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (sb_flush) begin
                for (int r = 0; r < 32; r++) m_busy[k][r] = 1'b0;
            end else begin
                if (we0)    m_busy[k][waddr0] = 1'b0;
                if (we1)    m_busy[k][waddr1] = 1'b0;
                if (sb_set) m_busy[k][sb_addr] = 1'b1;
            end
            if (cfg_zr(k)) m_busy[k][0] = 1'b0;
            if (we0 && !(cfg_zr(k) && waddr0 == 0)) m_mem[k][waddr0] = wdata0;
            if (we1 && !(cfg_zr(k) && waddr1 == 0)) m_mem[k][waddr1] = wdata1;
            if (hi_we) m_hi[k] = hi_wdata;
            if (lo_we) m_lo[k] = lo_wdata;
        end
    endtask

    function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
        if (cfg_zr(k) && a == 0) return 32'h0;
        if (cfg_bp(k) && we1 && waddr1 == a) return wdata1;
        if (cfg_bp(k) && we0 && waddr0 == a) return wdata0;
        return m_mem[k][a];
    endfunction

    function automatic logic exp_busy(int k, logic [4:0] a);
        logic hit;
        hit = cfg_bp(k) && ((we1 && waddr1 == a) || (we0 && waddr0 == a));
        return m_busy[k][a] && !hit;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; hi_we = 0; lo_we = 0; sb_set = 0; sb_flush = 0;
        waddr0 = 0; waddr1 = 0; sb_addr = 0;
        wdata0 = 0; wdata1 = 0; hi_wdata = 0; lo_wdata = 0;
    endtask

    task automatic set_ra(int p, logic [4:0] a);
        raddr_a[p*5 +: 5] = a;
    endtask

    task automatic set_rb(int p, logic [4:0] a);
        raddr_b[p*5 +: 5] = a;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (rdata_a !== '0) begin errors++; $display("FAIL rst_rdata_a got %h exp 0", rdata_a); end
        checks++; if (rdata_b !== '0) begin errors++; $display("FAIL rst_rdata_b got %h exp 0", rdata_b); end
        checks++; if (rbusy_a !== '0 || rbusy_b !== '0) begin errors++; $display("FAIL rst_rbusy got %b/%b exp 0", rbusy_a, rbusy_b); end
        checks++; if (hi_rdata_a !== '0 || lo_rdata_a !== '0) begin errors++; $display("FAIL rst_hilo got %h/%h exp 0", hi_rdata_a, lo_rdata_a); end
        // A write issued while reset is held must be ignored.
        we0 = 1; waddr0 = 6; wdata0 = 32'h99;
        tick();
        idle(); set_ra(0, 6); set_rb(0, 6); #1;
        checks++; if (rdata_a[31:0] !== 32'h0) begin errors++; $display("FAIL rst_wr_ign_a got %h exp 0", rdata_a[31:0]); end
        checks++; if (rdata_b[31:0] !== 32'h0) begin errors++; $display("FAIL rst_wr_ign_b got %h exp 0", rdata_b[31:0]); end
        rst_n = 1'b1;
        we0 = 1; waddr0 = 5; wdata0 = 32'h1234;
        tick();
        idle(); set_ra(0, 5); set_rb(0, 5); #1;
        checks++; if (rdata_a[31:0] !== 32'h1234) begin errors++; $display("FAIL wr_r5_a got %h exp 1234", rdata_a[31:0]); end
        checks++; if (rdata_b[31:0] !== 32'h1234) begin errors++; $display("FAIL wr_r5_b got %h exp 1234", rdata_b[31:0]); end
        // Reset asserted mid-cycle must clear state immediately, without a clock edge.
        #2 rst_n = 1'b0; model_reset(); #1;
        checks++; if (rdata_a[31:0] !== 32'h0) begin errors++; $display("FAIL async_rst_a got %h exp 0", rdata_a[31:0]); end
        checks++; if (rdata_b[31:0] !== 32'h0) begin errors++; $display("FAIL async_rst_b got %h exp 0", rdata_b[31:0]); end
        tick();
        rst_n = 1'b1;
        we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF; set_ra(0, 0); set_rb(0, 0); #1;
        checks++; if (rdata_a[31:0] !== 32'h0) begin errors++; $display("FAIL r0_byp_a got %h exp 0", rdata_a[31:0]); end
        tick();
        idle(); #1;
        checks++; if (rdata_a[31:0] !== 32'h0) begin errors++; $display("FAIL r0_a got %h exp 0", rdata_a[31:0]); end
        checks++; if (rdata_b[31:0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL r0_b got %h exp ffffffff", rdata_b[31:0]); end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_write_bypass();
        we0 = 1; waddr0 = 3; wdata0 = 32'hDEAD_BEEF; set_ra(0, 3); set_rb(0, 3); #1;
        checks++; if (rdata_a[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL byp_a got %h exp deadbeef", rdata_a[31:0]); end
        checks++; if (rdata_b[31:0] !== 32'h0) begin errors++; $display("FAIL nobyp_b got %h exp 0", rdata_b[31:0]); end
        tick();
        idle(); #1;
        checks++; if (rdata_a[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_a got %h exp deadbeef", rdata_a[31:0]); end
        checks++; if (rdata_b[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_b got %h exp deadbeef", rdata_b[31:0]); end
        $display("test_write_bypass done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_collision();
        we0 = 1; waddr0 = 7; wdata0 = 32'h1; we1 = 1; waddr1 = 7; wdata1 = 32'h2;
        set_ra(0, 7); set_rb(0, 7); #1;
        checks++; if (rdata_a[31:0] !== 32'h2) begin errors++; $display("FAIL coll_byp_a got %h exp 2", rdata_a[31:0]); end
        tick();
        idle(); #1;
        checks++; if (rdata_a[31:0] !== 32'h2) begin errors++; $display("FAIL coll_a got %h exp 2", rdata_a[31:0]); end
        checks++; if (rdata_b[31:0] !== 32'h2) begin errors++; $display("FAIL coll_b got %h exp 2", rdata_b[31:0]); end
        we0 = 1; waddr0 = 8; wdata0 = 32'hA; we1 = 1; waddr1 = 9; wdata1 = 32'hB;
        tick();
        idle(); set_ra(0, 8); set_ra(1, 9); set_rb(0, 8); set_rb(1, 9); #1;
        checks++; if (rdata_a[63:0] !== {32'hB, 32'hA}) begin errors++; $display("FAIL dual_a got %h exp b/a", rdata_a[63:0]); end
        checks++; if (rdata_b !== {32'hB, 32'hA}) begin errors++; $display("FAIL dual_b got %h exp b/a", rdata_b); end
        $display("test_collision done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_hilo();
        hi_we = 1; hi_wdata = 32'h55; lo_we = 1; lo_wdata = 32'hAA;
        we0 = 1; waddr0 = 4; wdata0 = 32'h77; #1;
        checks++; if (hi_rdata_a !== 32'h55 || lo_rdata_a !== 32'hAA) begin errors++; $display("FAIL hilo_byp_a got %h/%h exp 55/aa", hi_rdata_a, lo_rdata_a); end
        checks++; if (hi_rdata_b !== 32'h0) begin errors++; $display("FAIL hi_nobyp_b got %h exp 0", hi_rdata_b); end
        tick();
        idle(); set_ra(0, 4); set_rb(0, 4); #1;
        checks++; if (hi_rdata_b !== 32'h55 || lo_rdata_b !== 32'hAA) begin errors++; $display("FAIL hilo_b got %h/%h exp 55/aa", hi_rdata_b, lo_rdata_b); end
        checks++; if (hi_rdata_a !== 32'h55 || lo_rdata_a !== 32'hAA) begin errors++; $display("FAIL hilo_a got %h/%h exp 55/aa", hi_rdata_a, lo_rdata_a); end
        checks++; if (rdata_a[31:0] !== 32'h77) begin errors++; $display("FAIL hilo_r4_a got %h exp 77", rdata_a[31:0]); end
        $display("test_hilo done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_scoreboard();
        sb_set = 1; sb_addr = 10; set_ra(0, 10); set_rb(0, 10); #1;
        checks++; if (rbusy_a[0] !== 1'b0) begin errors++; $display("FAIL sb_early got %b exp 0", rbusy_a[0]); end
        tick();
        idle(); #1;
        checks++; if (rbusy_a[0] !== 1'b1 || rbusy_b[0] !== 1'b1) begin errors++; $display("FAIL sb_set got %b/%b exp 1/1", rbusy_a[0], rbusy_b[0]); end
        // A writeback and a new issue to r10 land in the same cycle.
        we1 = 1; waddr1 = 10; wdata1 = 32'h10; sb_set = 1; sb_addr = 10; #1;
        checks++; if (rbusy_a[0] !== 1'b0 || rbusy_b[0] !== 1'b1) begin errors++; $display("FAIL sb_byp_mask got %b/%b exp 0/1", rbusy_a[0], rbusy_b[0]); end
        tick();
        idle(); #1;
        checks++; if (rbusy_a[0] !== 1'b1 || rbusy_b[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b/%b exp 1/1", rbusy_a[0], rbusy_b[0]); end
        we0 = 1; waddr0 = 10; wdata0 = 32'h20;
        tick();
        idle(); #1;
        checks++; if (rbusy_a[0] !== 1'b0 || rbusy_b[0] !== 1'b0) begin errors++; $display("FAIL sb_clear got %b/%b exp 0/0", rbusy_a[0], rbusy_b[0]); end
        sb_set = 1; sb_addr = 12;
        tick();
        idle(); sb_flush = 1; sb_set = 1; sb_addr = 11;
        tick();
        idle(); set_ra(0, 11); set_ra(1, 12); set_rb(0, 11); set_rb(1, 12); #1;
        checks++; if (rbusy_a[1:0] !== 2'b00 || rbusy_b !== 2'b00) begin errors++; $display("FAIL sb_flush got %b/%b exp 00/00", rbusy_a[1:0], rbusy_b); end
        sb_set = 1; sb_addr = 0;
        tick();
        idle(); set_ra(0, 0); set_rb(0, 0); #1;
        checks++; if (rbusy_a[0] !== 1'b0 || rbusy_b[0] !== 1'b1) begin errors++; $display("FAIL sb_r0 got %b/%b exp 0/1", rbusy_a[0], rbusy_b[0]); end
        sb_flush = 1;
        tick();
        idle();
        $display("test_scoreboard done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_nr4();
        we0 = 1; waddr0 = 1; wdata0 = 32'h1111; we1 = 1; waddr1 = 2; wdata1 = 32'h2222;
        tick();
        we0 = 1; waddr0 = 3; wdata0 = 32'h3333; we1 = 1; waddr1 = 4; wdata1 = 32'h4444;
        tick();
        idle();
        for (int p = 0; p < 4; p++) set_ra(p, 5'(p + 1));
        set_rb(0, 3); set_rb(1, 4);
        #1;
        checks++; if (rdata_a !== {32'h4444, 32'h3333, 32'h2222, 32'h1111}) begin errors++; $display("FAIL nr4_ports got %h", rdata_a); end
        we1 = 1; waddr1 = 3; wdata1 = 32'hC3C3; #1;
        checks++; if (rdata_a !== {32'h4444, 32'hC3C3, 32'h2222, 32'h1111}) begin errors++; $display("FAIL nr4_port2_byp got %h exp 4444/c3c3/2222/1111", rdata_a); end
        checks++; if (rdata_b[31:0] !== 32'h3333) begin errors++; $display("FAIL nr4_nobyp_b got %h exp 3333", rdata_b[31:0]); end
        tick();
        idle();
        $display("test_nr4 done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            waddr0 = 5'($urandom_range(0, 7));
            waddr1 = 5'($urandom_range(0, 7));
            wdata0 = $urandom; wdata1 = $urandom;
            hi_we = 1'($urandom_range(0, 1)); hi_wdata = $urandom;
            lo_we = 1'($urandom_range(0, 1)); lo_wdata = $urandom;
            sb_set = 1'($urandom_range(0, 1)); sb_addr = 5'($urandom_range(0, 7));
            sb_flush = ($urandom_range(0, 15) == 0);
            raddr_a = 20'($urandom);
            for (int p = 0; p < 4; p++) if ($urandom_range(0, 1) == 1) set_ra(p, 5'($urandom_range(0, 7)));
            for (int p = 0; p < 2; p++) set_rb(p, 5'($urandom_range(0, 7)));
            #1;
            for (int p = 0; p < 4; p++) begin
                a = raddr_a[p*5 +: 5];
                checks++;
                if (rdata_a[p*32 +: 32] !== exp_rd(0, a)) begin
                    errors++; $display("FAIL rnd_rd_a%0d cyc %0d addr %0d got %h exp %h", p, n, a, rdata_a[p*32 +: 32], exp_rd(0, a));
                end
                checks++;
                if (rbusy_a[p] !== exp_busy(0, a)) begin
                    errors++; $display("FAIL rnd_busy_a%0d cyc %0d addr %0d got %b exp %b", p, n, a, rbusy_a[p], exp_busy(0, a));
                end
            end
            for (int p = 0; p < 2; p++) begin
                a = raddr_b[p*5 +: 5];
                checks++;
                if (rdata_b[p*32 +: 32] !== exp_rd(1, a)) begin
                    errors++; $display("FAIL rnd_rd_b%0d cyc %0d addr %0d got %h exp %h", p, n, a, rdata_b[p*32 +: 32], exp_rd(1, a));
                end
                checks++;
                if (rbusy_b[p] !== exp_busy(1, a)) begin
                    errors++; $display("FAIL rnd_busy_b%0d cyc %0d addr %0d got %b exp %b", p, n, a, rbusy_b[p], exp_busy(1, a));
                end
            end
            checks++;
            if (hi_rdata_a !== (hi_we ? hi_wdata : m_hi[0]) || lo_rdata_a !== (lo_we ? lo_wdata : m_lo[0])) begin
                errors++; $display("FAIL rnd_hilo_a cyc %0d got %h/%h", n, hi_rdata_a, lo_rdata_a);
            end
            checks++;
            if (hi_rdata_b !== m_hi[1] || lo_rdata_b !== m_lo[1]) begin
                errors++; $display("FAIL rnd_hilo_b cyc %0d got %h/%h exp %h/%h", n, hi_rdata_b, lo_rdata_b, m_hi[1], m_lo[1]);
            end
            tick();
        end
        idle();
        $display("test_random done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        raddr_a = '0;
        raddr_b = '0;
        model_reset();
        tick();
        tick();
        test_reset();
        test_write_bypass();
        test_collision();
        test_hilo();
        test_scoreboard();
        test_nr4();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
